// File: rtl/lightsaber_pwm.sv
// -----------------------------------------------------------------------------
// lightsaber_pwm
//
// Three-channel (red/green/blue) PWM driver for the lightsaber LED.
//
// A colour/brightness update arrives over a valid/ready handshake and is held
// in shadow registers. The shadow is copied into the active duty registers
// only at a PWM frame boundary, or immediately while the PWM is disabled.
// This means a running frame never mixes two colours. The three PWM outputs
// share one prescaler and one phase counter, so they stay phase-aligned.
// All outputs are driven straight from flops, so they are glitch-free.
//
// Parameters
//   PRESCALE     clk cycles per PWM phase step, legal range 1..65535
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous reset, active-high
//   en           PWM run enable; while low the counters are held at zero
//   col_valid    Ri/Gi/Bi/bright carry an update this cycle
//   col_ready    an update can be accepted (no update is pending)
//   Ri, Gi, Bi   8-bit channel colour values
//   bright       8-bit master brightness
//   pwm_r/g/b    registered PWM outputs
//   frame_start  one-cycle pulse on the first cycle of each new frame
// -----------------------------------------------------------------------------
module lightsaber_pwm #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       col_valid,
    output logic       col_ready,
    input  logic [7:0] Ri,
    input  logic [7:0] Gi,
    input  logic [7:0] Bi,
    input  logic [7:0] bright,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       frame_start
);

    localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 32'd1);
    // The phase never reaches 255, so a duty of 255 stays high for the whole frame.
    localparam logic [7:0]  PHASE_LAST = 8'd254;

    // Scales a channel value by (bright + 1) / 256. bright = 255 returns the
    // channel value unchanged, and bright = 0 always returns zero.
    function automatic logic [7:0] scale_duty(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = 17'(c) * (17'(b) + 17'd1);
        return 8'(prod >> 8);
    endfunction

    // Counter state
    logic [15:0] pre_q,   pre_d;
    logic [7:0]  phase_q, phase_d;

    // Shadow (staged update) and handshake state
    logic [7:0]  sh_r_q,      sh_r_d;
    logic [7:0]  sh_g_q,      sh_g_d;
    logic [7:0]  sh_b_q,      sh_b_d;
    logic [7:0]  sh_bright_q, sh_bright_d;
    logic        pending_q,   pending_d;
    logic        ready_q,     ready_d;

    // Active duties
    logic [7:0]  dr_q, dr_d;
    logic [7:0]  dg_q, dg_d;
    logic [7:0]  db_q, db_d;

    // Output flops
    logic        pwm_r_q, pwm_r_d;
    logic        pwm_g_q, pwm_g_d;
    logic        pwm_b_q, pwm_b_d;
    logic        frame_start_q, frame_start_d;

    // Event strobes
    logic        tick_s;
    logic        wrap_s;
    logic        accept_s;
    logic        xfer_s;

    // Decode the per-cycle events: prescaler tick, frame wrap, accept, transfer.
    always_comb begin
        tick_s   = en && (pre_q == PRE_LAST);
        wrap_s   = tick_s && (phase_q == PHASE_LAST);
        accept_s = col_valid && !pending_q;
        // While disabled there is no frame in progress, so a pending update
        // is committed right away. The first frame after en rises then uses it.
        xfer_s   = pending_q && (wrap_s || !en);
    end

    // Next state for the prescaler and the phase counter.
    always_comb begin
        pre_d   = pre_q;
        phase_d = phase_q;
        if (!en) begin
            pre_d   = 16'd0;
            phase_d = 8'd0;
        end else if (tick_s) begin
            pre_d = 16'd0;
            if (wrap_s) begin
                phase_d = 8'd0;
            end else begin
                phase_d = phase_q + 8'd1;
            end
        end else begin
            pre_d = pre_q + 16'd1;
        end
    end

    // Next state for the shadow registers and the pending/ready handshake.
    always_comb begin
        sh_r_d      = sh_r_q;
        sh_g_d      = sh_g_q;
        sh_b_d      = sh_b_q;
        sh_bright_d = sh_bright_q;
        pending_d   = pending_q;
        if (accept_s) begin
            sh_r_d      = Ri;
            sh_g_d      = Gi;
            sh_b_d      = Bi;
            sh_bright_d = bright;
            pending_d   = 1'b1;
        end else if (xfer_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        // Registered copy of !pending, so col_ready comes straight from a flop.
        ready_d = !pending_d;
    end

    // Next state for the active duties, which load from the scaled shadow on transfer.
    always_comb begin
        dr_d = dr_q;
        dg_d = dg_q;
        db_d = db_q;
        if (xfer_s) begin
            dr_d = scale_duty(sh_r_q, sh_bright_q);
            dg_d = scale_duty(sh_g_q, sh_bright_q);
            db_d = scale_duty(sh_b_q, sh_bright_q);
        end else begin
            dr_d = dr_q;
            dg_d = dg_q;
            db_d = db_q;
        end
    end

    // Next state for the PWM compare outputs and the frame-start pulse.
    always_comb begin
        pwm_r_d       = en && (phase_q < dr_q);
        pwm_g_d       = en && (phase_q < dg_q);
        pwm_b_d       = en && (phase_q < db_q);
        frame_start_d = wrap_s;
    end

    // State register for the whole block, with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q         <= 16'd0;
            phase_q       <= 8'd0;
            sh_r_q        <= 8'd0;
            sh_g_q        <= 8'd0;
            sh_b_q        <= 8'd0;
            sh_bright_q   <= 8'd0;
            pending_q     <= 1'b0;
            ready_q       <= 1'b1;
            dr_q          <= 8'd0;
            dg_q          <= 8'd0;
            db_q          <= 8'd0;
            pwm_r_q       <= 1'b0;
            pwm_g_q       <= 1'b0;
            pwm_b_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            phase_q       <= phase_d;
            sh_r_q        <= sh_r_d;
            sh_g_q        <= sh_g_d;
            sh_b_q        <= sh_b_d;
            sh_bright_q   <= sh_bright_d;
            pending_q     <= pending_d;
            ready_q       <= ready_d;
            dr_q          <= dr_d;
            dg_q          <= dg_d;
            db_q          <= db_d;
            pwm_r_q       <= pwm_r_d;
            pwm_g_q       <= pwm_g_d;
            pwm_b_q       <= pwm_b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign col_ready   = ready_q;
    assign pwm_r       = pwm_r_q;
    assign pwm_g       = pwm_g_q;
    assign pwm_b       = pwm_b_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lightsaber_pwm.sv
// -----------------------------------------------------------------------------
// tb_lightsaber_pwm
//
// Table-driven bench for lightsaber_pwm with PRESCALE = 2, so one frame lasts
// 510 cycles. Each table record holds a colour/brightness update and the
// hand-computed high-cycle count per channel. A frame with duty d is high for
// exactly the first 2*d cycles. Hand-written sequences cover reset/idle,
// backpressure, disable with a pending update, and asynchronous reset in the
// middle of a frame.
// -----------------------------------------------------------------------------
module tb_lightsaber_pwm;

    localparam int unsigned PRESCALE = 2;
    localparam int          FRAME    = 255 * PRESCALE;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       col_valid;
    logic       col_ready;
    logic [7:0] Ri, Gi, Bi, bright;
    logic       pwm_r, pwm_g, pwm_b;
    logic       frame_start;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] br;
        int         hr;   // expected high cycles per frame, red
        int         hg;
        int         hb;
    } vec_t;

    vec_t vecs[7];

    lightsaber_pwm #(.PRESCALE(PRESCALE)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .Ri          (Ri),
        .Gi          (Gi),
        .Bi          (Bi),
        .bright      (bright),
        .pwm_r       (pwm_r),
        .pwm_g       (pwm_g),
        .pwm_b       (pwm_b),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for col_ready, then presents one update for one edge.
    task automatic apply_update(input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b, input logic [7:0] br,
                                input string tag);
        int waited = 0;
        while (!col_ready && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " ready before update"}, int'(col_ready), 1);
        col_valid = 1'b1;
        Ri = r; Gi = g; Bi = b; bright = br;
        @(negedge clk);
        col_valid = 1'b0;
        check({tag, " ready low after accept"}, int'(col_ready), 0);
    endtask

    // Waits (bounded) until col_ready rises. With en=1 that is the first cycle of a frame.
    task automatic wait_xfer(input string tag, output int waited);
        waited = 0;
        while (!col_ready && waited < 2 * FRAME + 4) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " transfer reached"}, int'(col_ready), 1);
        check({tag, " frame_start with ready"}, int'(frame_start), 1);
    endtask

    // Called at a frame_start sample. Checks the next full frame cycle by cycle.
    task automatic measure_frame(input int hr, input int hg, input int hb, input string tag);
        int cr = 0, cg = 0, cb = 0;
        int br_ = 0, bg_ = 0, bb_ = 0;
        int fs = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            col_valid = 1'b0;
            if (pwm_r) cr++;
            if (pwm_g) cg++;
            if (pwm_b) cb++;
            if (pwm_r != ((k - 1) < hr)) br_++;
            if (pwm_g != ((k - 1) < hg)) bg_++;
            if (pwm_b != ((k - 1) < hb)) bb_++;
            if (frame_start) fs++;
        end
        check({tag, " r high count"}, cr, hr);
        check({tag, " g high count"}, cg, hg);
        check({tag, " b high count"}, cb, hb);
        check({tag, " r shape errors"}, br_, 0);
        check({tag, " g shape errors"}, bg_, 0);
        check({tag, " b shape errors"}, bb_, 0);
        check({tag, " frame_start count"}, fs, 1);
        check({tag, " frame_start at period end"}, int'(frame_start), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int fs_cnt;
        int hi_cnt;
        int nr_cnt;
        int e_g, e_r, e_b, e_fs;

        vecs[0] = '{r: 8'd128, g: 8'd0,   b: 8'd255, br: 8'd255, hr: 256, hg: 0,   hb: 510};
        vecs[1] = '{r: 8'd200, g: 8'd0,   b: 8'd0,   br: 8'd127, hr: 200, hg: 0,   hb: 0};
        vecs[2] = '{r: 8'd200, g: 8'd0,   b: 8'd0,   br: 8'd0,   hr: 0,   hg: 0,   hb: 0};
        vecs[3] = '{r: 8'd255, g: 8'd255, b: 8'd255, br: 8'd255, hr: 510, hg: 510, hb: 510};
        vecs[4] = '{r: 8'd1,   g: 8'd255, b: 8'd100, br: 8'd255, hr: 2,   hg: 510, hb: 200};
        vecs[5] = '{r: 8'd255, g: 8'd128, b: 8'd64,  br: 8'd128, hr: 256, hg: 128, hb: 64};
        vecs[6] = '{r: 8'd100, g: 8'd50,  b: 8'd3,   br: 8'd200, hr: 156, hg: 78,  hb: 4};

        // ---- Reset, then idle with en=0 ----
        rst = 1'b1; en = 1'b0; col_valid = 1'b0;
        Ri = 8'd0; Gi = 8'd0; Bi = 8'd0; bright = 8'd0;
        @(negedge clk);
        check("reset pwm_r", int'(pwm_r), 0);
        check("reset pwm_g", int'(pwm_g), 0);
        check("reset pwm_b", int'(pwm_b), 0);
        check("reset col_ready", int'(col_ready), 1);
        check("reset frame_start", int'(frame_start), 0);
        @(negedge clk);
        rst = 1'b0;
        fs_cnt = 0; hi_cnt = 0; nr_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (frame_start) fs_cnt++;
            if (pwm_r || pwm_g || pwm_b) hi_cnt++;
            if (!col_ready) nr_cnt++;
        end
        check("idle frame_start pulses", fs_cnt, 0);
        check("idle pwm high cycles", hi_cnt, 0);
        check("idle ready low cycles", nr_cnt, 0);

        // ---- Table-driven colour loads ----
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            apply_update(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].br, $sformatf("vec%0d", i));
            wait_xfer($sformatf("vec%0d", i), waited);
            measure_frame(vecs[i].hr, vecs[i].hg, vecs[i].hb, $sformatf("vec%0d", i));
        end

        // ---- Backpressure: R=10 accepted, R=99 held until ready ----
        apply_update(8'd10, 8'd0, 8'd0, 8'd255, "bp");
        col_valid = 1'b1;
        Ri = 8'd99; Gi = 8'd0; Bi = 8'd0; bright = 8'd255;
        wait_xfer("bp", waited);
        // Accepted right after a frame_start sample, so ready stays low for one frame minus one cycle.
        check("bp ready low cycles", waited, FRAME - 1);
        measure_frame(20, 0, 0, "bp first");
        measure_frame(198, 0, 0, "bp second");

        // ---- Disable with a pending update ----
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("dis pwm off", int'(pwm_r | pwm_g | pwm_b), 0);
        fs_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_start) fs_cnt++;
        end
        check("dis no frame_start", fs_cnt, 0);
        apply_update(8'd0, 8'd64, 8'd0, 8'd255, "dis");
        @(negedge clk);
        check("dis transfer next edge", int'(col_ready), 1);
        check("dis pwm_g still off", int'(pwm_g), 0);
        en = 1'b1;
        e_g = 0; e_r = 0; e_b = 0; e_fs = 0; hi_cnt = 0;
        for (int n = 0; n < FRAME; n++) begin
            @(negedge clk);
            if (pwm_g) hi_cnt++;
            if (pwm_g != (n < 128)) e_g++;
            if (pwm_r) e_r++;
            if (pwm_b) e_b++;
            if (frame_start != (n == FRAME - 1)) e_fs++;
        end
        check("en rise pwm_g high count", hi_cnt, 128);
        check("en rise pwm_g shape errors", e_g, 0);
        check("en rise pwm_r high", e_r, 0);
        check("en rise pwm_b high", e_b, 0);
        check("en rise frame_start errors", e_fs, 0);

        // ---- Asynchronous reset mid-frame with an update pending ----
        apply_update(8'd255, 8'd255, 8'd255, 8'd255, "arst full");
        wait_xfer("arst full", waited);
        apply_update(8'd5, 8'd5, 8'd5, 8'd255, "arst pend");
        for (int i = 0; i < 199; i++) @(negedge clk);
        check("arst pre pwm all high", int'(pwm_r & pwm_g & pwm_b), 1);
        check("arst pre ready low", int'(col_ready), 0);
        rst = 1'b1;
        #1;
        check("arst pwm_r no edge", int'(pwm_r), 0);
        check("arst pwm_g no edge", int'(pwm_g), 0);
        check("arst pwm_b no edge", int'(pwm_b), 0);
        check("arst col_ready no edge", int'(col_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        waited = 0;
        while (!frame_start && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        check("arst frame_start after release", int'(frame_start), 1);
        check("arst ready stays high", int'(col_ready), 1);
        measure_frame(0, 0, 0, "arst after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
